// File: rtl/csr_file_rmw.sv
// csr_file_rmw: a small CSR file with a general register bank and two
// 2*XLEN-bit counters (cycle, instret). It supports WRITE/SET/CLEAR
// read-modify-write operations. Reads are combinational and return the
// value before this cycle's update. Updates commit on the next rising edge.
module csr_file_rmw #(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 8,
  parameter logic [11:0] BANK_BASE = 12'h340
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = 2 * XLEN;
  localparam logic [12:0] BANK_LO = {1'b0, BANK_BASE};
  localparam logic [12:0] BANK_HI = BANK_LO + 13'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [11:0] A_CYCLE     = 12'hB00;
  localparam logic [11:0] A_CYCLEH    = 12'hB80;
  localparam logic [11:0] A_INSTRET   = 12'hB02;
  localparam logic [11:0] A_INSTRETH  = 12'hB82;
  localparam logic [11:0] A_CYCLE_RO    = 12'hC00;
  localparam logic [11:0] A_CYCLEH_RO   = 12'hC80;
  localparam logic [11:0] A_INSTRET_RO  = 12'hC02;
  localparam logic [11:0] A_INSTRETH_RO = 12'hC82;

  logic [XLEN-1:0]  bank_q [DEPTH];
  logic [CW-1:0]    cycle_q;
  logic [CW-1:0]    instret_q;

  csr_op_e          op;
  logic [12:0]      addr_ext;
  logic             in_bank;
  logic [IDX_W-1:0] bank_idx;
  logic             hit_cycle_lo;
  logic             hit_cycle_hi;
  logic             hit_instret_lo;
  logic             hit_instret_hi;
  logic             read_only;
  logic             mapped;
  logic             write_req;
  logic             commit;
  logic             cycle_wr;
  logic             instret_wr;
  logic [XLEN-1:0]  new_val;

  // Address decode and legality.
  // SET/CLEAR with an empty mask is a pure read, so it never counts as a write.
  always_comb begin
    op             = csr_op_e'(csr_op);
    addr_ext       = {1'b0, csr_addr};
    in_bank        = (addr_ext >= BANK_LO) && (addr_ext < BANK_HI);
    bank_idx       = IDX_W'(addr_ext - BANK_LO);
    hit_cycle_lo   = (csr_addr == A_CYCLE)    || (csr_addr == A_CYCLE_RO);
    hit_cycle_hi   = (csr_addr == A_CYCLEH)   || (csr_addr == A_CYCLEH_RO);
    hit_instret_lo = (csr_addr == A_INSTRET)  || (csr_addr == A_INSTRET_RO);
    hit_instret_hi = (csr_addr == A_INSTRETH) || (csr_addr == A_INSTRETH_RO);
    read_only      = (csr_addr[11:8] == 4'hC);
    mapped         = in_bank || hit_cycle_lo || hit_cycle_hi ||
                     hit_instret_lo || hit_instret_hi;
    write_req      = (op == OP_WRITE) ||
                     (((op == OP_SET) || (op == OP_CLEAR)) && (csr_wdata != '0));
    csr_illegal    = (op != OP_NONE) && (!mapped || (read_only && write_req));
    commit         = write_req && !csr_illegal;
    cycle_wr       = commit && (hit_cycle_lo || hit_cycle_hi);
    instret_wr     = commit && (hit_instret_lo || hit_instret_hi);
  end

  // Read mux returns the pre-update value. Unmapped addresses read as zero.
  always_comb begin
    csr_rdata = '0;
    if (in_bank) begin
      csr_rdata = bank_q[bank_idx];
    end else if (hit_cycle_lo) begin
      csr_rdata = cycle_q[XLEN-1:0];
    end else if (hit_cycle_hi) begin
      csr_rdata = cycle_q[CW-1:XLEN];
    end else if (hit_instret_lo) begin
      csr_rdata = instret_q[XLEN-1:0];
    end else if (hit_instret_hi) begin
      csr_rdata = instret_q[CW-1:XLEN];
    end
  end

  // Compute the read-modify-write result from the current read value.
  always_comb begin
    new_val = csr_rdata;
    case (op)
      OP_WRITE: new_val = csr_wdata;
      OP_SET:   new_val = csr_rdata | csr_wdata;
      OP_CLEAR: new_val = csr_rdata & ~csr_wdata;
      default:  new_val = csr_rdata;
    endcase
  end

  // Bank registers take the committed value at the decoded index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (commit && in_bank) begin
      bank_q[bank_idx] <= new_val;
    end
  end

  // The cycle counter free-runs. A software write to either half wins for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
    end else if (cycle_wr) begin
      if (hit_cycle_hi) begin
        cycle_q[CW-1:XLEN] <= new_val;
      end else begin
        cycle_q[XLEN-1:0] <= new_val;
      end
    end else begin
      cycle_q <= cycle_q + CNT_ONE;
    end
  end

  // The instret counter counts retirements. A software write to either half wins for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (instret_wr) begin
      if (hit_instret_hi) begin
        instret_q[CW-1:XLEN] <= new_val;
      end else begin
        instret_q[XLEN-1:0] <= new_val;
      end
    end else if (retire) begin
      instret_q <= instret_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_csr_file_rmw.sv
// Testbench for csr_file_rmw. It runs directed scenarios followed by random
// traffic. Every access is compared against a behavioural model of the CSR map.
module tb_csr_file_rmw;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 8;
  localparam logic [11:0] BASE  = 12'h340;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] SET   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            retire;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  int total  = 0;
  int passed = 0;

  // Model state: plain arrays and 64-bit integers.
  logic [31:0] m_bank [DEPTH];
  logic [63:0] m_cycle;
  logic [63:0] m_instret;

  csr_file_rmw #(.XLEN(XLEN), .DEPTH(DEPTH), .BANK_BASE(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .retire      (retire),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  function automatic bit model_in_bank(input logic [11:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (model_in_bank(a)) return m_bank[int'(a) - int'(BASE)];
    case (a)
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      default:          return 32'h0;
    endcase
  endfunction

  function automatic bit model_mapped(input logic [11:0] a);
    return model_in_bank(a) || (a == 12'hB00) || (a == 12'hB80) || (a == 12'hB02) ||
           (a == 12'hB82) || (a == 12'hC00) || (a == 12'hC80) || (a == 12'hC02) ||
           (a == 12'hC82);
  endfunction

  function automatic bit model_writes(input logic [1:0] op, input logic [31:0] wd);
    if (op == WRITE) return 1'b1;
    if (op == SET || op == CLEAR) return wd != 32'h0;
    return 1'b0;
  endfunction

  function automatic bit model_illegal(input logic [1:0] op, input logic [11:0] a,
                                       input logic [31:0] wd);
    if (op == NONE) return 1'b0;
    if (!model_mapped(a)) return 1'b1;
    return (a >= 12'hC00) && (a <= 12'hCFF) && model_writes(op, wd);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bank[i] = 32'h0;
    m_cycle   = 64'h0;
    m_instret = 64'h0;
  endtask

  // Apply one clock edge's worth of architectural effect.
  task automatic model_commit(input logic [1:0] op, input logic [11:0] a,
                              input logic [31:0] wd, input logic ret);
    logic [31:0] old;
    logic [31:0] nv;
    bit cyc_w;
    bit ins_w;
    old   = model_read(a);
    cyc_w = 1'b0;
    ins_w = 1'b0;
    nv    = (op == WRITE) ? wd : (op == SET) ? (old | wd) : (old & ~wd);
    if (model_writes(op, wd) && !model_illegal(op, a, wd)) begin
      if (model_in_bank(a)) m_bank[int'(a) - int'(BASE)] = nv;
      else if (a == 12'hB00) begin m_cycle[31:0]    = nv; cyc_w = 1'b1; end
      else if (a == 12'hB80) begin m_cycle[63:32]   = nv; cyc_w = 1'b1; end
      else if (a == 12'hB02) begin m_instret[31:0]  = nv; ins_w = 1'b1; end
      else if (a == 12'hB82) begin m_instret[63:32] = nv; ins_w = 1'b1; end
    end
    if (!cyc_w) m_cycle = m_cycle + 64'd1;
    if (!ins_w && ret) m_instret = m_instret + 64'd1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Drive one access for one clock. Check it before the edge, then advance the model.
  task automatic apply_stimulus(input logic [1:0] op, input logic [11:0] a,
                                input logic [31:0] wd, input logic ret, input string tag,
                                input bit use_k, input logic [31:0] k);
    @(negedge clk);
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = wd;
    retire    = ret;
    #1;
    check_output({tag, "_rdata"}, csr_rdata, model_read(a));
    check_output({tag, "_illegal"}, {31'b0, csr_illegal}, {31'b0, model_illegal(op, a, wd)});
    if (use_k) check_output({tag, "_const"}, csr_rdata, k);
    @(posedge clk);
    if (!rst) model_commit(op, a, wd, ret);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst    = 1'b0;
    csr_op = NONE;
    retire = 1'b0;
    @(posedge clk);
    model_commit(NONE, 12'h000, 32'h0, 1'b0);
  endtask

  initial begin
    logic [11:0] pool [18];
    logic [1:0]  rop;
    logic [11:0] raddr;
    logic [31:0] rwd;

    rst       = 1'b1;
    csr_op    = NONE;
    csr_addr  = 12'h000;
    csr_wdata = 32'h0;
    retire    = 1'b0;
    model_reset();

    // Reset state: everything reads zero, and writes are ignored while in reset.
    apply_stimulus(WRITE, 12'h340, 32'h1111_1111, 1'b1, "reset_wr", 1'b1, 32'h0);
    apply_stimulus(NONE,  12'h340, 32'h0,         1'b0, "reset_bank", 1'b1, 32'h0);
    apply_stimulus(NONE,  12'hB00, 32'h0,         1'b0, "reset_cycle", 1'b1, 32'h0);
    release_reset();
    apply_stimulus(NONE,  12'hB00, 32'h0,         1'b0, "first_inc", 1'b1, 32'h1);

    // Write followed by set: the set cycle sees the old value, and the next cycle sees the merged value.
    apply_stimulus(WRITE, 12'h340, 32'hA5A5_0000, 1'b0, "w340", 1'b0, 32'h0);
    apply_stimulus(SET,   12'h340, 32'h0000_00FF, 1'b0, "set340", 1'b1, 32'hA5A5_0000);
    apply_stimulus(NONE,  12'h340, 32'h0,         1'b0, "rd340", 1'b1, 32'hA5A5_00FF);

    // A zero-mask clear is a pure read. An out-of-range bank write is illegal.
    apply_stimulus(WRITE, 12'h341, 32'h0000_1234, 1'b0, "w341", 1'b0, 32'h0);
    apply_stimulus(CLEAR, 12'h341, 32'h0,         1'b0, "clr0_341", 1'b1, 32'h1234);
    apply_stimulus(NONE,  12'h341, 32'h0,         1'b0, "rd341", 1'b1, 32'h1234);
    apply_stimulus(WRITE, 12'h348, 32'h5,         1'b0, "w348", 1'b1, 32'h0);
    apply_stimulus(CLEAR, 12'h341, 32'h0000_0004, 1'b0, "clr341", 1'b1, 32'h1234);
    apply_stimulus(NONE,  12'h341, 32'h0,         1'b0, "rd341b", 1'b1, 32'h1230);

    // Low-half carry propagates into the high half.
    apply_stimulus(WRITE, 12'hB00, 32'hFFFF_FFFF, 1'b0, "wcyc", 1'b0, 32'h0);
    apply_stimulus(NONE,  12'hB00, 32'h0,         1'b0, "cyc_ff", 1'b1, 32'hFFFF_FFFF);
    apply_stimulus(NONE,  12'hB00, 32'h0,         1'b0, "cyc_wrap", 1'b1, 32'h0);
    apply_stimulus(NONE,  12'hB80, 32'h0,         1'b0, "cyc_hi", 1'b1, 32'h1);

    // The read-only alias rejects writes but allows a zero-mask set.
    apply_stimulus(WRITE, 12'hC00, 32'h5,         1'b0, "wc00", 1'b0, 32'h0);
    apply_stimulus(SET,   12'hC00, 32'h0,         1'b0, "setc00", 1'b0, 32'h0);
    apply_stimulus(NONE,  12'hC80, 32'h0,         1'b0, "rdc80", 1'b1, 32'h1);

    // retire is held for 10 cycles, with an instret write at index 3.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus((i == 3) ? WRITE : NONE, 12'hB02, 32'd100, 1'b1, "instret_seq",
                     (i == 4), 32'd100);
    end
    apply_stimulus(NONE, 12'hB02, 32'h0, 1'b0, "instret_final", 1'b1, 32'd106);
    apply_stimulus(NONE, 12'hB82, 32'h0, 1'b0, "instret_hi", 1'b1, 32'h0);

    // Reset asserted between edges while a write is pending.
    apply_stimulus(WRITE, 12'h342, 32'h5555_5555, 1'b0, "w342", 1'b0, 32'h0);
    @(negedge clk);
    csr_op    = WRITE;
    csr_addr  = 12'h342;
    csr_wdata = 32'hDEAD_BEEF;
    retire    = 1'b1;
    #1 rst = 1'b1;
    model_reset();
    #1 check_output("rst_mid_bank", csr_rdata, 32'h0);
    csr_addr = 12'hB00;
    #1 check_output("rst_mid_cycle", csr_rdata, 32'h0);
    csr_addr = 12'h342;
    @(posedge clk);
    release_reset();
    apply_stimulus(NONE, 12'hB00, 32'h0, 1'b0, "post_rst_cyc", 1'b1, 32'h1);
    apply_stimulus(NONE, 12'h342, 32'h0, 1'b0, "post_rst_bank", 1'b1, 32'h0);
    apply_stimulus(NONE, 12'hB02, 32'h0, 1'b0, "post_rst_ins", 1'b1, 32'h0);

    // Random traffic over mapped, aliased and unmapped addresses.
    pool = '{12'h33F, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h345, 12'h346,
             12'h347, 12'h348, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
             12'hC02, 12'hC82};
    for (int n = 0; n < 300; n++) begin
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) raddr = 12'($urandom);
      else raddr = pool[$urandom_range(0, 17)];
      rwd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      apply_stimulus(rop, raddr, rwd, 1'($urandom_range(0, 1)), "rand", 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
